axi_tlb_miss_log: RTL and testbench
===================================

// Module: axi_tlb_miss_log
// PURPOSE
// Consumes the TLB-miss events produced by the AXI TLB slave-side demux, i.e. AW/AR handshakes routed to the error slave.
// Records each miss (address, ID, direction) in a small FIFO that software or a page-table-walk agent drains.
// Keeps saturating per-direction miss counters and a sticky overflow flag.
// Sits beside the TLB top level; its event inputs are driven by the miss-select/handshake terms of the slave demux.
// PARAMETERS
// AddrWidth  48  width of logged slave-port address
// IdWidth     4  width of logged AXI ID
// Depth       4  FIFO entries; legal range 2..64, need not be a power of 2
// CntWidth   16  width of each miss counter
// PORTS
// clk_i            in   1          rising-edge clock
// rst_i            in   1          synchronous reset, active-high
// wr_miss_valid_i  in   1          one-cycle pulse: AW handshake completed with TLB miss
// wr_miss_addr_i   in   AddrWidth  AW address of that miss
// wr_miss_id_i     in   IdWidth    AW ID of that miss
// rd_miss_valid_i  in   1          one-cycle pulse: AR handshake completed with TLB miss
// rd_miss_addr_i   in   AddrWidth  AR address
// rd_miss_id_i     in   IdWidth    AR ID
// log_valid_o      out  1          FIFO head valid
// log_ready_i      in   1          consumer pops head when valid&ready
// log_addr_o       out  AddrWidth  head address
// log_id_o         out  IdWidth    head ID
// log_write_o      out  1          head direction: 1 = write (AW), 0 = read (AR)
// log_count_o      out  $clog2(Depth+1)  current occupancy
// wr_miss_cnt_o    out  CntWidth   saturating AW miss count
// rd_miss_cnt_o    out  CntWidth   saturating AR miss count
// overflow_o       out  1          sticky: at least one miss event was dropped
// clear_i          in   1          clears counters and overflow (not FIFO)
// flush_i          in   1          empties FIFO
// BEHAVIOUR
// - Reset: FIFO empty, log_valid_o=0, log_count_o=0, counters=0, overflow_o=0.
// - While FIFO is empty, log_addr_o, log_id_o and log_write_o are don't-care.
// - Storage is registered. A miss pushed in cycle t is visible on log_* at t+1 at the earliest; there is no fall-through.
// - Outputs come from the head register/array. Head fields are stable while log_valid_o=1 and log_ready_i=0.
// - Pop: log_valid_o & log_ready_i. Valid/ready follows AXI-stream rules; log_valid_o never drops without a pop or flush.
// - Free slots this cycle: free = Depth - count + pop.
//   - A pop in the same cycle frees a slot for that cycle's push.
// - Push order when both events arrive: the write miss is entered first, then the read miss. Up to 2 pushes per cycle.
// - Insufficient space:
//   - free==1 with both events: write is stored, read is dropped.
//   - free==0: all events are dropped.
//   - Any drop sets overflow_o the next cycle.
// - Counters count every event, stored or dropped:
//   - +1 per direction per pulse.
//   - Saturate at 2^CntWidth-1; no wrap.
// - clear_i has priority over same-cycle increments:
//   - Counters go to 0 and overflow_o goes to 0.
//   - The event itself is still pushed if space allows, but is not counted.
//   - A drop in the clear cycle does not set overflow_o.
// - flush_i has priority over push/pop in that cycle:
//   - FIFO becomes empty next cycle; events in the flush cycle are discarded.
//   - Discarded events are counted but not flagged as overflow.
// - Pointers wrap modulo Depth, including non-power-of-2 Depth.
// - log_count_o is an exact occupancy and never exceeds Depth.
// - rst_i asserted mid-operation: the next edge restores reset state regardless of other inputs.
// - Pulses with valid=0 are ignored; addr/id are sampled only on the valid cycle.
// TESTING
// 1. Single wr miss, addr=0x1000, id=3 at t, log_ready_i=0
//    -> t+1: log_valid_o=1, addr=0x1000, id=3, log_write_o=1, count=1, wr_miss_cnt_o=1.
// 2. Depth=4, both misses each cycle for 3 cycles, no pops
//    -> cycles 1-2 store W,R,W,R. Cycle 3: both dropped, overflow_o=1.
//    -> wr_miss_cnt_o=3, rd_miss_cnt_o=3. Pop order: W,R,W,R.
// 3. FIFO full, pop and one rd miss in the same cycle
//    -> rd miss is stored, count stays 4, overflow_o stays 0.
// 4. CntWidth=4, 20 wr misses draining each cycle -> wr_miss_cnt_o saturates at 15.
//    Then clear_i with a simultaneous wr miss -> counter=0 and the entry is logged.
// 5. flush_i with 3 entries and a same-cycle rd miss -> next cycle count=0, log_valid_o=0.
//    rd_miss_cnt_o increments; overflow_o unchanged.
// 6. Depth=3 wrap: push/pop 10 entries with ramp addresses (0,1,2,...) and random log_ready_i
//    -> in-order output, no loss, no overflow.
//    Assert rst_i mid-sequence -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/axi_tlb_miss_log.sv
// -----------------------------------------------------------------------------
// axi_tlb_miss_log
//
// Records TLB-miss events (AW/AR handshakes routed to the error slave) in a
// small in-order FIFO for software or a page-table-walk agent to drain.
// It also keeps saturating per-direction miss counters and a sticky flag that
// reports dropped events.
//
// Ports
//   clk_i, rst_i          rising-edge clock, synchronous active-high reset
//   wr_miss_valid_i/addr/id   one-cycle AW miss event and its attributes
//   rd_miss_valid_i/addr/id   one-cycle AR miss event and its attributes
//   log_valid_o/ready_i   valid/ready pop interface for the FIFO head
//   log_addr_o/id_o/write_o   head entry fields (write = 1 for AW)
//   log_count_o           exact FIFO occupancy (0..Depth)
//   wr_miss_cnt_o         saturating AW miss count
//   rd_miss_cnt_o         saturating AR miss count
//   overflow_o            sticky flag: an event was dropped for lack of space
//   clear_i               clears the counters and overflow_o (FIFO untouched)
//   flush_i               empties the FIFO
// -----------------------------------------------------------------------------
module axi_tlb_miss_log #(
   parameter int AddrWidth = 48,
   parameter int IdWidth   = 4,
   parameter int Depth     = 4,
   parameter int CntWidth  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_miss_valid_i,
   input  logic [AddrWidth-1:0]         wr_miss_addr_i,
   input  logic [IdWidth-1:0]           wr_miss_id_i,
   input  logic                         rd_miss_valid_i,
   input  logic [AddrWidth-1:0]         rd_miss_addr_i,
   input  logic [IdWidth-1:0]           rd_miss_id_i,
   output logic                         log_valid_o,
   input  logic                         log_ready_i,
   output logic [AddrWidth-1:0]         log_addr_o,
   output logic [IdWidth-1:0]           log_id_o,
   output logic                         log_write_o,
   output logic [$clog2(Depth+1)-1:0]   log_count_o,
   output logic [CntWidth-1:0]          wr_miss_cnt_o,
   output logic [CntWidth-1:0]          rd_miss_cnt_o,
   output logic                         overflow_o,
   input  logic                         clear_i,
   input  logic                         flush_i
);

   localparam int PtrW  = $clog2(Depth);
   localparam int CntW  = $clog2(Depth+1);
   // One extra bit so Depth - count + pop cannot wrap.
   localparam int FreeW = CntW + 1;
   localparam int EntW  = AddrWidth + IdWidth + 1;
   localparam logic [PtrW-1:0]     LastPtr = PtrW'(Depth - 1);
   localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

   // Pointer advance with explicit wrap, so non-power-of-2 depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      logic [PtrW-1:0] n;
      if (p == LastPtr) begin
         n = {PtrW{1'b0}};
      end else begin
         n = p + PtrW'(1);
      end
      return n;
   endfunction

   logic [EntW-1:0]     r_mem [Depth];
   logic [PtrW-1:0]     r_wr_ptr;
   logic [PtrW-1:0]     r_rd_ptr;
   logic [CntW-1:0]     r_count;
   logic [CntWidth-1:0] r_wr_cnt;
   logic [CntWidth-1:0] r_rd_cnt;
   logic                r_overflow;

   logic                w_pop;
   logic [FreeW-1:0]    w_free;
   logic [FreeW-1:0]    w_need_rd;
   logic                w_push_wr;
   logic                w_push_rd;
   logic                w_drop;
   logic [PtrW-1:0]     w_wr_ptr_p1;
   logic [PtrW-1:0]     w_rd_slot;
   logic [PtrW-1:0]     w_wr_ptr_nxt;
   logic [PtrW-1:0]     w_rd_ptr_nxt;
   logic [CntW-1:0]     w_count_nxt;
   logic [EntW-1:0]     w_head;

   // Push/pop decisions: write miss takes the first free slot, read the next.
   always_comb begin
      w_pop       = (r_count != {CntW{1'b0}}) && log_ready_i;
      w_free      = FreeW'(Depth) - FreeW'(r_count) + FreeW'(w_pop);
      w_need_rd   = wr_miss_valid_i ? FreeW'(2) : FreeW'(1);
      w_push_wr   = wr_miss_valid_i && (w_free != {FreeW{1'b0}});
      w_push_rd   = rd_miss_valid_i && (w_free >= w_need_rd);
      w_drop      = (wr_miss_valid_i && !w_push_wr) || (rd_miss_valid_i && !w_push_rd);
      w_wr_ptr_p1 = ptr_inc(r_wr_ptr);
      // A stored read lands behind a same-cycle write; if the write was
      // dropped the read was dropped too, so the slot is then unused.
      w_rd_slot   = wr_miss_valid_i ? w_wr_ptr_p1 : r_wr_ptr;
      if (w_push_wr && w_push_rd) begin
         w_wr_ptr_nxt = ptr_inc(w_wr_ptr_p1);
      end else if (w_push_wr || w_push_rd) begin
         w_wr_ptr_nxt = w_wr_ptr_p1;
      end else begin
         w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
         w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
      end else begin
         w_rd_ptr_nxt = r_rd_ptr;
      end
      w_count_nxt = r_count + CntW'(w_push_wr) + CntW'(w_push_rd) - CntW'(w_pop);
   end

   // Entry storage; contents are meaningless while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         if (w_push_wr) begin
            r_mem[r_wr_ptr] <= {1'b1, wr_miss_id_i, wr_miss_addr_i};
         end
         if (w_push_rd) begin
            r_mem[w_rd_slot] <= {1'b0, rd_miss_id_i, rd_miss_addr_i};
         end
      end
   end

   // FIFO pointers and occupancy; flush wins over same-cycle push/pop.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_wr_ptr <= {PtrW{1'b0}};
         r_rd_ptr <= {PtrW{1'b0}};
         r_count  <= {CntW{1'b0}};
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Saturating counters and sticky overflow; clear wins over increments.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wr_cnt   <= {CntWidth{1'b0}};
         r_rd_cnt   <= {CntWidth{1'b0}};
         r_overflow <= 1'b0;
      end else begin
         if (wr_miss_valid_i && (r_wr_cnt != CntMax)) begin
            r_wr_cnt <= r_wr_cnt + CntWidth'(1);
         end
         if (rd_miss_valid_i && (r_rd_cnt != CntMax)) begin
            r_rd_cnt <= r_rd_cnt + CntWidth'(1);
         end
         // Events discarded by a flush are intentional, not an overflow.
         if (w_drop && !flush_i) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_head        = r_mem[r_rd_ptr];
   assign log_valid_o   = (r_count != {CntW{1'b0}});
   assign log_write_o   = w_head[EntW-1];
   assign log_id_o      = w_head[AddrWidth +: IdWidth];
   assign log_addr_o    = w_head[AddrWidth-1:0];
   assign log_count_o   = r_count;
   assign wr_miss_cnt_o = r_wr_cnt;
   assign rd_miss_cnt_o = r_rd_cnt;
   assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_axi_tlb_miss_log.sv
// Bench for axi_tlb_miss_log. Instance A: Depth=4, CntWidth=4.
// Instance B: Depth=3, CntWidth=16 (wrap scenario). Both share stimulus.
// The reference model is a queue plus integer counters.
module tb_axi_tlb_miss_log;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, wv, rv, rdy, clr, fl;
   logic [47:0] wa, ra;
   logic [3:0]  wid, rid;

   logic        a_valid, a_write, a_ov;
   logic [47:0] a_addr;
   logic [3:0]  a_id;
   logic [2:0]  a_count;
   logic [3:0]  a_wc, a_rc;

   logic        b_valid, b_write, b_ov;
   logic [47:0] b_addr;
   logic [3:0]  b_id;
   logic [1:0]  b_count;
   logic [15:0] b_wc, b_rc;

   axi_tlb_miss_log #(.AddrWidth(48), .IdWidth(4), .Depth(4), .CntWidth(4)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .wr_miss_valid_i(wv), .wr_miss_addr_i(wa), .wr_miss_id_i(wid),
      .rd_miss_valid_i(rv), .rd_miss_addr_i(ra), .rd_miss_id_i(rid),
      .log_valid_o(a_valid), .log_ready_i(rdy), .log_addr_o(a_addr),
      .log_id_o(a_id), .log_write_o(a_write), .log_count_o(a_count),
      .wr_miss_cnt_o(a_wc), .rd_miss_cnt_o(a_rc), .overflow_o(a_ov),
      .clear_i(clr), .flush_i(fl));

   axi_tlb_miss_log #(.AddrWidth(48), .IdWidth(4), .Depth(3), .CntWidth(16)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .wr_miss_valid_i(wv), .wr_miss_addr_i(wa), .wr_miss_id_i(wid),
      .rd_miss_valid_i(rv), .rd_miss_addr_i(ra), .rd_miss_id_i(rid),
      .log_valid_o(b_valid), .log_ready_i(rdy), .log_addr_o(b_addr),
      .log_id_o(b_id), .log_write_o(b_write), .log_count_o(b_count),
      .wr_miss_cnt_o(b_wc), .rd_miss_cnt_o(b_rc), .overflow_o(b_ov),
      .clear_i(clr), .flush_i(fl));

   // Reference model state
   logic [52:0] q[$];
   int          m_wc, m_rc, m_depth, m_cmax;
   bit          m_ov;
   bit          use_b;
   int          vectors = 0;
   int          miscompares = 0;

   wire [36:0] obs_a = {a_valid, a_count, 12'd0, a_wc, 12'd0, a_rc, a_ov};
   wire [36:0] obs_b = {b_valid, 1'b0, b_count, b_wc, b_rc, b_ov};

   function automatic logic [36:0] obs_s();
      return use_b ? obs_b : obs_a;
   endfunction

   function automatic logic [52:0] head_s();
      return use_b ? {b_write, b_id, b_addr} : {a_write, a_id, a_addr};
   endfunction

   function automatic logic [36:0] exp_state();
      return {q.size() != 0, 3'(q.size()), 16'(m_wc), 16'(m_rc), m_ov};
   endfunction

   task automatic idle();
      wv = 1'b0; rv = 1'b0; clr = 1'b0; fl = 1'b0; rdy = 1'b0;
      wa = 48'd0; ra = 48'd0; wid = 4'd0; rid = 4'd0;
   endtask

   // Advance one clock and apply the specification's rules to the model.
   task automatic step();
      bit drop;
      @(posedge clk);
      if (rst) begin
         q.delete(); m_wc = 0; m_rc = 0; m_ov = 1'b0;
      end else begin
         drop = 1'b0;
         if (fl) begin
            q.delete();
         end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (wv) begin
               if (q.size() < m_depth) q.push_back({1'b1, wid, wa});
               else drop = 1'b1;
            end
            if (rv) begin
               if (q.size() < m_depth) q.push_back({1'b0, rid, ra});
               else drop = 1'b1;
            end
         end
         if (clr) begin
            m_wc = 0; m_rc = 0; m_ov = 1'b0;
         end else begin
            if (wv && m_wc < m_cmax) m_wc++;
            if (rv && m_rc < m_cmax) m_rc++;
            if (drop) m_ov = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset(input bit sel_b);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      use_b   = sel_b;
      m_depth = sel_b ? 3 : 4;
      m_cmax  = sel_b ? 65535 : 15;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wv = 1'b1; rv = 1'b1; rdy = 1'b1; clr = 1'b0; fl = 1'b0;
      wa = 48'($urandom); ra = 48'($urandom); wid = 4'($urandom); rid = 4'($urandom);
      step();
      rst = 1'b0; idle();
      use_b = 1'b0; m_depth = 4; m_cmax = 15;
      vectors++;
      if (obs_a !== 37'd0) begin
         miscompares++; $display("FAIL reset_a: got %h exp %h", obs_a, 37'd0);
      end
      vectors++;
      if (obs_b !== 37'd0) begin
         miscompares++; $display("FAIL reset_b: got %h exp %h", obs_b, 37'd0);
      end
   endtask

   task automatic test_single();
      do_reset(1'b0);
      wv = 1'b1; wa = 48'h1000; wid = 4'd3;
      step();
      idle();
      vectors++;
      if ({a_valid, a_addr, a_id, a_write, a_count, a_wc} !== {1'b1, 48'h1000, 4'd3, 1'b1, 3'd1, 4'd1}) begin
         miscompares++;
         $display("FAIL single: got v=%b a=%h id=%0d w=%b c=%0d wc=%0d exp v=1 a=1000 id=3 w=1 c=1 wc=1",
                  a_valid, a_addr, a_id, a_write, a_count, a_wc);
      end
      for (int i = 0; i < 3; i++) begin
         rdy = (i == 2);
         step();
         vectors++;
         if (obs_s() !== exp_state()) begin
            miscompares++; $display("FAIL single_hold: got %h exp %h", obs_s(), exp_state());
         end
      end
      idle();
   endtask

   task automatic test_overflow();
      logic [48:0] exp_seq [4];
      exp_seq[0] = {1'b1, 48'h100}; exp_seq[1] = {1'b0, 48'h200};
      exp_seq[2] = {1'b1, 48'h101}; exp_seq[3] = {1'b0, 48'h201};
      do_reset(1'b0);
      for (int c = 0; c < 3; c++) begin
         wv = 1'b1; rv = 1'b1;
         wa = 48'h100 + 48'(c); ra = 48'h200 + 48'(c);
         wid = 4'($urandom); rid = 4'($urandom);
         step();
         vectors++;
         if (obs_s() !== exp_state()) begin
            miscompares++; $display("FAIL ovf_fill: got %h exp %h", obs_s(), exp_state());
         end
      end
      idle();
      vectors++;
      if ({a_count, a_wc, a_rc, a_ov} !== {3'd4, 4'd3, 4'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL ovf_state: got c=%0d wc=%0d rc=%0d ov=%b exp c=4 wc=3 rc=3 ov=1",
                  a_count, a_wc, a_rc, a_ov);
      end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({a_valid, a_write, a_addr} !== {1'b1, exp_seq[i]}) begin
            miscompares++;
            $display("FAIL ovf_order: got v=%b w=%b a=%h exp w=%b a=%h",
                     a_valid, a_write, a_addr, exp_seq[i][48], exp_seq[i][47:0]);
         end
         step();
      end
      idle();
   endtask

   task automatic test_full_pop_push();
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         wv = 1'b1; wa = 48'($urandom); wid = 4'($urandom);
         step();
      end
      idle();
      rdy = 1'b1; rv = 1'b1; ra = 48'hABC; rid = 4'd9;
      step();
      idle();
      vectors++;
      if ({a_count, a_ov} !== {3'd4, 1'b0}) begin
         miscompares++; $display("FAIL full_pop_push: got c=%0d ov=%b exp c=4 ov=0", a_count, a_ov);
      end
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (obs_s() !== exp_state() || head_s() !== q[0]) begin
            miscompares++;
            $display("FAIL full_drain: got %h/%h exp %h/%h", obs_s(), head_s(), exp_state(), q[0]);
         end
         step();
      end
      idle();
   endtask

   task automatic test_saturate();
      do_reset(1'b0);
      rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wv = 1'b1; wa = 48'(i); wid = 4'($urandom);
         step();
         vectors++;
         if (obs_s() !== exp_state()) begin
            miscompares++; $display("FAIL sat_step%0d: got %h exp %h", i, obs_s(), exp_state());
         end
      end
      vectors++;
      if (a_wc !== 4'd15) begin
         miscompares++; $display("FAIL sat_value: got %0d exp 15", a_wc);
      end
      rdy = 1'b0; clr = 1'b1; wv = 1'b1; wa = 48'h5A5A; wid = 4'd7;
      step();
      idle();
      vectors++;
      if ({a_wc, a_count} !== {4'd0, 3'd2}) begin
         miscompares++; $display("FAIL sat_clear: got wc=%0d c=%0d exp wc=0 c=2", a_wc, a_count);
      end
      rdy = 1'b1;
      step();
      idle();
      vectors++;
      if ({a_valid, a_write, a_id, a_addr} !== {1'b1, 1'b1, 4'd7, 48'h5A5A}) begin
         miscompares++;
         $display("FAIL sat_logged: got v=%b w=%b id=%0d a=%h exp v=1 w=1 id=7 a=5a5a",
                  a_valid, a_write, a_id, a_addr);
      end
   endtask

   task automatic test_flush();
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) begin
         wv = 1'b1; wa = 48'($urandom); wid = 4'($urandom);
         step();
      end
      idle();
      fl = 1'b1; rv = 1'b1; ra = 48'h77; rdy = 1'b1;
      step();
      idle();
      vectors++;
      if ({a_valid, a_count, a_rc, a_wc, a_ov} !== {1'b0, 3'd0, 4'd1, 4'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL flush: got v=%b c=%0d rc=%0d wc=%0d ov=%b exp v=0 c=0 rc=1 wc=3 ov=0",
                  a_valid, a_count, a_rc, a_wc, a_ov);
      end
   endtask

   task automatic test_random();
      do_reset(1'b0);
      for (int i = 0; i < 400; i++) begin
         wv  = ($urandom_range(1, 0) == 1);
         rv  = ($urandom_range(1, 0) == 1);
         rdy = ($urandom_range(2, 0) == 0);
         clr = ($urandom_range(15, 0) == 0);
         fl  = ($urandom_range(19, 0) == 0);
         wa = {16'($urandom), 32'($urandom)}; ra = {16'($urandom), 32'($urandom)};
         wid = 4'($urandom); rid = 4'($urandom);
         step();
         vectors++;
         if (obs_s() !== exp_state()) begin
            miscompares++; $display("FAIL rand_state%0d: got %h exp %h", i, obs_s(), exp_state());
         end
         if (q.size() > 0) begin
            vectors++;
            if (head_s() !== q[0]) begin
               miscompares++; $display("FAIL rand_head%0d: got %h exp %h", i, head_s(), q[0]);
            end
         end
      end
      idle();
   endtask

   task automatic test_wrap();
      logic [47:0] popped[$];
      int nxt;
      nxt = 0;
      do_reset(1'b1);
      for (int i = 0; i < 300 && popped.size() < 10; i++) begin
         rdy = ($urandom_range(1, 0) == 1);
         wv  = (nxt < 10) && (q.size() < 3);
         wa  = 48'(nxt); wid = 4'(nxt);
         if (b_valid && rdy) popped.push_back(b_addr);
         step();
         if (wv) nxt++;
         vectors++;
         if (obs_s() !== exp_state()) begin
            miscompares++; $display("FAIL wrap_state%0d: got %h exp %h", i, obs_s(), exp_state());
         end
      end
      idle();
      vectors++;
      if (popped.size() != 10 || b_ov !== 1'b0) begin
         miscompares++; $display("FAIL wrap_done: got %0d pops ov=%b exp 10 pops ov=0", popped.size(), b_ov);
      end
      for (int i = 0; i < popped.size(); i++) begin
         vectors++;
         if (popped[i] !== 48'(i)) begin
            miscompares++; $display("FAIL wrap_order%0d: got %h exp %h", i, popped[i], 48'(i));
         end
      end
      // Refill partially, then reset with every other input active.
      wv = 1'b1; rv = 1'b1; wa = 48'h33; ra = 48'h44;
      step();
      rst = 1'b1; clr = 1'b0; fl = 1'b0; rdy = 1'b0;
      step();
      rst = 1'b0; idle();
      vectors++;
      if (obs_b !== 37'd0 || obs_a !== 37'd0) begin
         miscompares++; $display("FAIL mid_reset: got b=%h a=%h exp 0", obs_b, obs_a);
      end
   endtask

   initial begin
      rst = 1'b1; idle();
      use_b = 1'b0; m_depth = 4; m_cmax = 15;
      q.delete(); m_wc = 0; m_rc = 0; m_ov = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_pop_push();
      test_saturate();
      test_flush();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
